// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: core write-back has priority, a colliding
// long-latency-unit result is parked and drained later, with a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_wb_en,
    input  logic [4:0]        core_rd,
    input  logic [DATA_W-1:0] core_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [4:0]        lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              issue_en,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        rs1_index,
    input  logic [4:0]        rs2_index,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              core_stall,
    output logic              issue_err,
    output logic              wb_en,
    output logic [4:0]        rd_index,
    output logic [DATA_W-1:0] wb_data
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, DEFER, FORCE} state_t;

    state_t              state_reg, state_next;
    logic                hold_vld_reg, hold_vld_next;
    logic [4:0]          hold_rd_reg, hold_rd_next;
    logic [DATA_W-1:0]   hold_data_reg, hold_data_next;
    logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [31:0]         pending_reg, pending_next;
    logic                core_stall_reg;
    logic                issue_err_reg;

    logic                creq;
    logic                lu_commit;
    logic [4:0]          commit_rd;
    logic                issue_set;

    assign creq      = core_wb_en && (core_rd != 5'd0);
    assign issue_set = issue_en && (issue_rd != 5'd0);

    always_comb begin
        state_next     = state_reg;
        hold_vld_next  = hold_vld_reg;
        hold_rd_next   = hold_rd_reg;
        hold_data_next = hold_data_reg;
        wait_cnt_next  = wait_cnt_reg;
        lu_ready       = 1'b0;
        lu_commit      = 1'b0;
        commit_rd      = 5'd0;
        wb_en          = 1'b0;
        rd_index       = 5'd0;
        wb_data        = '0;

        case (state_reg)
            IDLE: begin
                lu_ready = 1'b1;
                if (creq) begin
                    wb_en    = 1'b1;
                    rd_index = core_rd;
                    wb_data  = core_data;
                    if (lu_valid) begin
                        hold_vld_next  = 1'b1;
                        hold_rd_next   = lu_rd;
                        hold_data_next = lu_data;
                        wait_cnt_next  = CNT_W'(1);
                        state_next     = DEFER;
                    end
                end else if (lu_valid) begin
                    // x0 results are accepted but never reach the register file
                    lu_commit = 1'b1;
                    commit_rd = lu_rd;
                    if (lu_rd != 5'd0) begin
                        wb_en    = 1'b1;
                        rd_index = lu_rd;
                        wb_data  = lu_data;
                    end
                end
            end

            DEFER: begin
                if (!creq) begin
                    lu_commit     = 1'b1;
                    commit_rd     = hold_rd_reg;
                    wb_en         = (hold_rd_reg != 5'd0);
                    rd_index      = wb_en ? hold_rd_reg : 5'd0;
                    wb_data       = wb_en ? hold_data_reg : '0;
                    hold_vld_next = 1'b0;
                    wait_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    // The core still wins on the cycle the limit is reached
                    wb_en    = 1'b1;
                    rd_index = core_rd;
                    wb_data  = core_data;
                    if (wait_cnt_reg == CNT_MAX) begin
                        state_next = FORCE;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                    end
                end
            end

            FORCE: begin
                lu_commit     = 1'b1;
                commit_rd     = hold_rd_reg;
                wb_en         = (hold_rd_reg != 5'd0);
                rd_index      = wb_en ? hold_rd_reg : 5'd0;
                wb_data       = wb_en ? hold_data_reg : '0;
                hold_vld_next = 1'b0;
                wait_cnt_next = '0;
                state_next    = IDLE;
            end

            default: begin
                hold_vld_next = 1'b0;
                wait_cnt_next = '0;
                state_next    = IDLE;
            end
        endcase
    end

    // Per-register scoreboard update; a new issue outranks a same-cycle commit
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pending
            if (gi == 0) begin : g_x0
                assign pending_next[gi] = 1'b0;
            end else begin : g_xn
                assign pending_next[gi] =
                    (pending_reg[gi] && !(lu_commit && (commit_rd == 5'(gi)))) ||
                    (issue_set && (issue_rd == 5'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hold_vld_reg   <= 1'b0;
            hold_rd_reg    <= 5'd0;
            hold_data_reg  <= '0;
            wait_cnt_reg   <= '0;
            pending_reg    <= 32'd0;
            core_stall_reg <= 1'b0;
            issue_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_vld_reg   <= hold_vld_next;
            hold_rd_reg    <= hold_rd_next;
            hold_data_reg  <= hold_data_next;
            wait_cnt_reg   <= wait_cnt_next;
            pending_reg    <= pending_next;
            core_stall_reg <= (state_next == FORCE);
            issue_err_reg  <= issue_set && pending_reg[issue_rd];
        end
    end

    assign core_stall = core_stall_reg;
    assign issue_err  = issue_err_reg;
    assign rs1_busy   = pending_reg[rs1_index];
    assign rs2_busy   = pending_reg[rs2_index];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1ns after each rising edge,
// outputs are checked 4ns after the edge.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_wb_en;
    logic [4:0]        core_rd;
    logic [DATA_W-1:0] core_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [4:0]        lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              issue_en;
    logic [4:0]        issue_rd;
    logic [4:0]        rs1_index;
    logic [4:0]        rs2_index;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              core_stall;
    logic              issue_err;
    logic              wb_en;
    logic [4:0]        rd_index;
    logic [DATA_W-1:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_wb_en(core_wb_en), .core_rd(core_rd), .core_data(core_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .core_stall(core_stall), .issue_err(issue_err),
        .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_wb_en = 1'b0; core_rd = 5'd0; core_data = '0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = '0;
        issue_en = 1'b0; issue_rd = 5'd0;
    endtask

    task automatic core_wr(input logic [4:0] rd, input logic [31:0] d);
        core_wb_en = 1'b1; core_rd = rd; core_data = d;
    endtask

    task automatic lu_wr(input logic [4:0] rd, input logic [31:0] d);
        lu_valid = 1'b1; lu_rd = rd; lu_data = d;
    endtask

    task automatic port(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".wb_en"}, 32'(wb_en), 32'(en));
        chk({tag, ".rd_index"}, 32'(rd_index), 32'(rd));
        chk({tag, ".wb_data"}, wb_data, d);
    endtask

    initial begin
        // 1: reset held for two edges with every input active
        rst_n = 1'b0;
        core_wr(5'd3, 32'h11); lu_wr(5'd7, 32'h22);
        issue_en = 1'b1; issue_rd = 5'd9;
        rs1_index = 5'd9; rs2_index = 5'd7;
        step(); step(); #3;
        chk("rst.rs1_busy", 32'(rs1_busy), 0);
        chk("rst.rs2_busy", 32'(rs2_busy), 0);
        chk("rst.core_stall", 32'(core_stall), 0);
        chk("rst.issue_err", 32'(issue_err), 0);
        chk("rst.lu_ready", 32'(lu_ready), 1);
        idle_inputs(); #1;
        port("rst", 1'b0, 5'd0, 32'h0);

        // 2: passthrough
        step(); rst_n = 1'b1;
        lu_wr(5'd5, 32'hDEAD); #3;
        port("pass", 1'b1, 5'd5, 32'hDEAD);
        chk("pass.lu_ready", 32'(lu_ready), 1);

        // 3: collision, then drain when core idles
        step(); idle_inputs();
        core_wr(5'd3, 32'h11); lu_wr(5'd7, 32'h22); #3;
        port("coll.c0", 1'b1, 5'd3, 32'h11);
        chk("coll.c0.lu_ready", 32'(lu_ready), 1);
        step(); idle_inputs(); #3;
        port("coll.c1", 1'b1, 5'd7, 32'h22);
        chk("coll.c1.lu_ready", 32'(lu_ready), 0);
        step(); #3;
        port("coll.c2", 1'b0, 5'd0, 32'h0);
        chk("coll.c2.lu_ready", 32'(lu_ready), 1);

        // 4: starvation with MAX_WAIT=4
        step(); core_wr(5'd3, 32'h100); lu_wr(5'd7, 32'h77); #3;
        port("starv.cap", 1'b1, 5'd3, 32'h100);
        for (int k = 1; k <= 4; k++) begin
            step(); idle_inputs(); core_wr(5'd3, 32'h100 + 32'(k)); #3;
            port($sformatf("starv.w%0d", k), 1'b1, 5'd3, 32'h100 + 32'(k));
            chk($sformatf("starv.w%0d.stall", k), 32'(core_stall), 0);
            chk($sformatf("starv.w%0d.lu_ready", k), 32'(lu_ready), 0);
        end
        step(); core_wr(5'd3, 32'h1FF); #3;
        chk("starv.force.stall", 32'(core_stall), 1);
        port("starv.force", 1'b1, 5'd7, 32'h77);
        chk("starv.force.lu_ready", 32'(lu_ready), 0);
        step(); core_wr(5'd3, 32'h200); #3;
        chk("starv.after.stall", 32'(core_stall), 0);
        port("starv.after", 1'b1, 5'd3, 32'h200);
        chk("starv.after.lu_ready", 32'(lu_ready), 1);

        // 5: scoreboard
        step(); idle_inputs();
        issue_en = 1'b1; issue_rd = 5'd9; rs1_index = 5'd9; rs2_index = 5'd0; #3;
        chk("sb.issue.busy", 32'(rs1_busy), 0);
        step(); idle_inputs(); #3;
        chk("sb.busy1", 32'(rs1_busy), 1);
        chk("sb.x0_busy", 32'(rs2_busy), 0);
        chk("sb.no_err", 32'(issue_err), 0);
        step(); lu_wr(5'd9, 32'h99); #3;
        port("sb.commit", 1'b1, 5'd9, 32'h99);
        chk("sb.commit.busy", 32'(rs1_busy), 1);
        step(); idle_inputs(); #3;
        chk("sb.cleared", 32'(rs1_busy), 0);
        step(); issue_en = 1'b1; issue_rd = 5'd9; #3;
        chk("sb.dup1.err", 32'(issue_err), 0);
        step(); #3;
        chk("sb.dup2.busy", 32'(rs1_busy), 1);
        chk("sb.dup2.err", 32'(issue_err), 0);
        step(); idle_inputs(); rs2_index = 5'd9; #3;
        chk("sb.err_pulse", 32'(issue_err), 1);
        chk("sb.rs2_busy", 32'(rs2_busy), 1);
        step(); #3;
        chk("sb.err_drop", 32'(issue_err), 0);
        // simultaneous commit and re-issue of x9: the set wins
        step(); lu_wr(5'd9, 32'h9A); issue_en = 1'b1; issue_rd = 5'd9; #3;
        step(); idle_inputs(); #3;
        chk("sb.setwins.busy", 32'(rs1_busy), 1);
        chk("sb.setwins.err", 32'(issue_err), 1);
        step(); lu_wr(5'd9, 32'h9B); #3;
        step(); idle_inputs(); #3;
        chk("sb.final_clear", 32'(rs1_busy), 0);

        // 6a: LU write to x0 is accepted but not written
        step(); lu_wr(5'd0, 32'h55); #3;
        chk("x0.wb_en", 32'(wb_en), 0);
        chk("x0.rd_index", 32'(rd_index), 0);
        chk("x0.lu_ready", 32'(lu_ready), 1);
        step(); idle_inputs(); #3;
        chk("x0.next.lu_ready", 32'(lu_ready), 1);

        // 6b: reset while a result is parked
        step(); issue_en = 1'b1; issue_rd = 5'd8; #3;
        step(); idle_inputs(); core_wr(5'd4, 32'h44); lu_wr(5'd8, 32'h88); rs1_index = 5'd8; #3;
        port("rdef.cap", 1'b1, 5'd4, 32'h44);
        chk("rdef.cap.busy", 32'(rs1_busy), 1);
        step(); idle_inputs(); rst_n = 1'b0; core_wr(5'd4, 32'h45); #3;
        chk("rdef.in_defer", 32'(lu_ready), 0);
        port("rdef.rst_cycle", 1'b1, 5'd4, 32'h45);
        step(); rst_n = 1'b1; idle_inputs(); #3;
        port("rdef.after", 1'b0, 5'd0, 32'h0);
        chk("rdef.after.lu_ready", 32'(lu_ready), 1);
        chk("rdef.after.busy", 32'(rs1_busy), 0);
        step(); #3;
        port("rdef.later", 1'b0, 5'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
